// File: rtl/mem_access.sv
// Memory access stage: turns load/store requests from decode into single
// data-bus transactions, aligns load data for writeback and flags
// misaligned accesses without touching the bus.
//
// Bus handshake: ram_en acts as valid. While ram_en=1, ram_addr,
// ram_write_en and ram_write_data stay stable until the cycle in which
// ram_ready=1. That cycle completes the transfer, and ram_read_data is
// consumed in the same cycle. ram_ready is ignored while ram_en=0.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] address,
  input  logic [31:0] result_in,
  input  logic        flush,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic [31:0] result,
  output logic        stall_request,
  output logic        load_addr_error,
  output logic        store_addr_error
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // state is the hook for external checkers.
  state_t state;
  state_t state_next;

  logic        access;
  logic        is_write;
  logic        misaligned;
  logic        issue;
  logic [31:0] store_rep;
  logic [31:0] load_data;
  logic [31:0] lane_shifted;

  logic [31:0] lat_addr;
  logic [3:0]  lat_sel;
  logic        lat_sign;
  logic        lat_write;
  logic [31:0] lat_wdata;

  // Decode the incoming request.
  // A write request wins when both flags are set.
  always_comb begin
    access     = (mem_read_flag | mem_write_flag) & (mem_sel != 4'b0000);
    is_write   = mem_write_flag;
    misaligned = ((mem_sel == 4'b1111) && (address[1:0] != 2'b00)) ||
                 ((mem_sel == 4'b0011) && address[0]);
    issue      = (state == IDLE) && access && !misaligned && !flush;
  end

  // Replicate store data across all byte lanes.
  // The byte enables then pick the lanes that the memory writes.
  always_comb begin
    case (mem_sel)
      4'b0001: store_rep = {4{mem_write_data[7:0]}};
      4'b0011: store_rep = {2{mem_write_data[15:0]}};
      default: store_rep = mem_write_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the request on issue.
  // These registers drive the bus for the whole BUSY period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= 32'h0;
      lat_sel   <= 4'h0;
      lat_sign  <= 1'b0;
      lat_write <= 1'b0;
      lat_wdata <= 32'h0;
    end else if (issue) begin
      lat_addr  <= address;
      lat_sel   <= mem_sel;
      lat_sign  <= mem_sign_ext_flag;
      lat_write <= is_write;
      lat_wdata <= store_rep;
    end
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    lane_shifted = ram_read_data >> {lat_addr[1:0], 3'b000};
    case (lat_sel)
      4'b0001: load_data = {{24{lat_sign & lane_shifted[7]}}, lane_shifted[7:0]};
      4'b0011: load_data = lat_addr[1] ?
                 {{16{lat_sign & ram_read_data[31]}}, ram_read_data[31:16]} :
                 {{16{lat_sign & ram_read_data[15]}}, ram_read_data[15:0]};
      default: load_data = ram_read_data;
    endcase
  end

  always_comb begin
    ram_addr       = {lat_addr[31:2], 2'b00};
    ram_write_data = lat_wdata;
  end

  // Compute the next state and the stage outputs.
  // Reset forces the outputs to zero immediately, even mid-transaction.
  always_comb begin
    state_next       = state;
    ram_en           = 1'b0;
    ram_write_en     = 4'b0000;
    stall_request    = 1'b0;
    result           = result_in;
    load_addr_error  = 1'b0;
    store_addr_error = 1'b0;
    case (state)
      IDLE: begin
        load_addr_error  = access && misaligned && !is_write;
        store_addr_error = access && misaligned && is_write;
        if (issue) begin
          stall_request = 1'b1;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        // flush is ignored here; a started transaction always completes.
        ram_en       = 1'b1;
        ram_write_en = lat_write ? (lat_sel << lat_addr[1:0]) : 4'b0000;
        if (ram_ready) begin
          state_next = IDLE;
          if (!lat_write) result = load_data;
        end else begin
          stall_request = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      state_next       = IDLE;
      ram_en           = 1'b0;
      ram_write_en     = 4'b0000;
      stall_request    = 1'b0;
      result           = 32'h0;
      load_addr_error  = 1'b0;
      store_addr_error = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access.
// Inputs change 1 ns after each rising edge. Outputs are checked 3 ns after
// each rising edge, well away from the active edge.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] address;
  logic [31:0] result_in;
  logic        flush;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic [31:0] result;
  logic        stall_request;
  logic        load_addr_error;
  logic        store_addr_error;

  int checks = 0;
  int errors = 0;
  int stall_cycles;

  mem_access dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_flag    (mem_read_flag),
    .mem_write_flag   (mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag),
    .mem_sel          (mem_sel),
    .mem_write_data   (mem_write_data),
    .address          (address),
    .result_in        (result_in),
    .flush            (flush),
    .ram_en           (ram_en),
    .ram_write_en     (ram_write_en),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data),
    .ram_ready        (ram_ready),
    .result           (result),
    .stall_request    (stall_request),
    .load_addr_error  (load_addr_error),
    .store_addr_error (store_addr_error)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_write_data    = 32'h0;
    address           = 32'h0;
    flush             = 1'b0;
    ram_ready         = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic sgn,
                     input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] wdata);
    mem_read_flag     = rd;
    mem_write_flag    = wr;
    mem_sign_ext_flag = sgn;
    mem_sel           = sel;
    address           = addr;
    mem_write_data    = wdata;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    idle_inputs();
    result_in     = 32'h0000_1234;
    ram_read_data = 32'h0;
    rst_n         = 1'b0;
    #3;
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_stall", {31'h0, stall_request}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_write_data, 32'h0);
    chk("rst_ram_we", {28'h0, ram_write_en}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Non-memory instruction passes result_in through.
    tick();
    result_in = 32'hDEAD_BEEF;
    settle();
    chk("pass_result", result, 32'hDEAD_BEEF);
    chk("pass_stall", {31'h0, stall_request}, 32'h0);
    chk("pass_ram_en", {31'h0, ram_en}, 32'h0);

    // SB 0xA5 @ 0x102
    tick();
    result_in = 32'h1111_2222;
    req(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0102, 32'h0000_00A5);
    settle();
    chk("sb_issue_stall", {31'h0, stall_request}, 32'h1);
    chk("sb_issue_ram_en", {31'h0, ram_en}, 32'h0);
    tick();
    settle();
    chk("sb_busy_ram_en", {31'h0, ram_en}, 32'h1);
    chk("sb_busy_we", {28'h0, ram_write_en}, 32'h4);
    chk("sb_busy_wdata", ram_write_data, 32'hA5A5_A5A5);
    chk("sb_busy_addr", ram_addr, 32'h0000_0100);
    chk("sb_busy_stall", {31'h0, stall_request}, 32'h1);
    tick();
    settle();
    chk("sb_hold_addr", ram_addr, 32'h0000_0100);
    chk("sb_hold_we", {28'h0, ram_write_en}, 32'h4);
    chk("sb_hold_stall", {31'h0, stall_request}, 32'h1);
    ram_ready = 1'b1;
    #1;
    chk("sb_done_stall", {31'h0, stall_request}, 32'h0);
    chk("sb_done_result", result, 32'h1111_2222);
    tick();
    idle_inputs();
    settle();
    chk("sb_back_idle", {31'h0, ram_en}, 32'h0);

    // LB signed @ 0x3, ready after 3 BUSY cycles
    tick();
    req(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_0003, 32'h0);
    ram_read_data = 32'h8000_0000;
    stall_cycles  = 0;
    settle();
    if (stall_request) stall_cycles++;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      if (stall_request) stall_cycles++;
      if (i == 0) chk("lb_busy_we", {28'h0, ram_write_en}, 32'h0);
    end
    tick();
    ram_ready = 1'b1;
    settle();
    chk("lb_stall_cycles", stall_cycles, 32'd4);
    chk("lb_ready_stall", {31'h0, stall_request}, 32'h0);
    chk("lb_result", result, 32'hFFFF_FF80);
    chk("lb_addr", ram_addr, 32'h0);
    tick();
    idle_inputs();

    // LHU @ 0x2, ready immediately
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_0002, 32'h0);
    ram_read_data = 32'hBEEF_1234;
    ram_ready     = 1'b1;
    settle();
    chk("lhu_issue_stall", {31'h0, stall_request}, 32'h1);
    tick();
    settle();
    chk("lhu_result", result, 32'h0000_BEEF);
    chk("lhu_stall", {31'h0, stall_request}, 32'h0);
    tick();
    idle_inputs();
    settle();
    chk("lhu_idle", {31'h0, ram_en}, 32'h0);

    // LBU @ 0x1 -> byte lane 1, zero-extended
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_0001, 32'h0);
    ram_read_data = 32'h0000_F000;
    ram_ready     = 1'b1;
    tick();
    settle();
    chk("lbu_result", result, 32'h0000_00F0);
    tick();
    idle_inputs();

    // LH signed @ 0x0
    tick();
    req(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0040, 32'h0);
    ram_read_data = 32'h7777_8001;
    ram_ready     = 1'b1;
    tick();
    settle();
    chk("lh_result", result, 32'hFFFF_8001);
    chk("lh_addr", ram_addr, 32'h0000_0040);
    tick();
    idle_inputs();

    // LW @ 0x80
    tick();
    req(1'b1, 1'b0, 1'b1, 4'b1111, 32'h0000_0080, 32'h0);
    ram_read_data = 32'h8234_5678;
    ram_ready     = 1'b1;
    tick();
    settle();
    chk("lw_result", result, 32'h8234_5678);
    tick();
    idle_inputs();

    // SH 0xBEEF @ 0x2 -> upper lanes
    tick();
    req(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0206, 32'h1234_BEEF);
    tick();
    settle();
    chk("sh_we", {28'h0, ram_write_en}, 32'hC);
    chk("sh_wdata", ram_write_data, 32'hBEEF_BEEF);
    chk("sh_addr", ram_addr, 32'h0000_0204);
    ram_ready = 1'b1;
    tick();
    idle_inputs();

    // Both flags set: the store wins
    tick();
    req(1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D);
    tick();
    settle();
    chk("sw_pri_we", {28'h0, ram_write_en}, 32'hF);
    chk("sw_pri_wdata", ram_write_data, 32'hCAFE_F00D);
    ram_ready     = 1'b1;
    ram_read_data = 32'h5555_5555;
    #1;
    chk("sw_pri_result", result, result_in);
    tick();
    idle_inputs();

    // Misaligned accesses
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0006, 32'h0);
    settle();
    chk("lw_mis_lerr", {31'h0, load_addr_error}, 32'h1);
    chk("lw_mis_serr", {31'h0, store_addr_error}, 32'h0);
    chk("lw_mis_stall", {31'h0, stall_request}, 32'h0);
    tick();
    settle();
    chk("lw_mis_ram_en", {31'h0, ram_en}, 32'h0);
    req(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0001, 32'h0);
    #1;
    chk("sh_mis_serr", {31'h0, store_addr_error}, 32'h1);
    chk("sh_mis_lerr", {31'h0, load_addr_error}, 32'h0);
    chk("sh_mis_stall", {31'h0, stall_request}, 32'h0);
    tick();
    settle();
    chk("sh_mis_ram_en", {31'h0, ram_en}, 32'h0);
    idle_inputs();

    // Reset during BUSY
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0300, 32'h0);
    tick();
    settle();
    chk("rstb_busy_ram_en", {31'h0, ram_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstb_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rstb_stall", {31'h0, stall_request}, 32'h0);
    chk("rstb_addr", ram_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0020, 32'h0);
    settle();
    chk("rstb_reissue_stall", {31'h0, stall_request}, 32'h1);
    chk("rstb_reissue_idle", {31'h0, ram_en}, 32'h0);
    tick();
    settle();
    chk("rstb_reissue_addr", ram_addr, 32'h0000_0020);
    chk("rstb_reissue_en", {31'h0, ram_en}, 32'h1);
    ram_ready = 1'b1;
    tick();
    idle_inputs();

    // Flush in IDLE suppresses the access
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0400, 32'h0);
    flush = 1'b1;
    settle();
    chk("flush_idle_stall", {31'h0, stall_request}, 32'h0);
    tick();
    settle();
    chk("flush_idle_ram_en", {31'h0, ram_en}, 32'h0);
    flush = 1'b0;
    idle_inputs();

    // Flush in BUSY is ignored
    tick();
    req(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0500, 32'h0);
    ram_read_data = 32'h0BAD_F00D;
    tick();
    flush = 1'b1;
    settle();
    chk("flush_busy_ram_en", {31'h0, ram_en}, 32'h1);
    chk("flush_busy_stall", {31'h0, stall_request}, 32'h1);
    tick();
    ram_ready = 1'b1;
    settle();
    chk("flush_busy_result", result, 32'h0BAD_F00D);
    chk("flush_busy_done", {31'h0, stall_request}, 32'h0);
    tick();
    idle_inputs();
    settle();
    chk("flush_busy_idle", {31'h0, ram_en}, 32'h0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case a wait never completes.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
